// File: rtl/iir_pkg.sv
// iir_pkg: shared types and constants for the biquad cascade
package iir_pkg;
  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, MAC3, MAC4, UPD} state_t;
  localparam int COEFS_PER_SEC = 5;
  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] A1 = 3'd3;
  localparam logic [2:0] A2 = 3'd4;
  function automatic int acc_width(input int n);
    return 2 * n + 3;
  endfunction
endpackage

// File: rtl/iir_sat_shift.sv
// iir_sat_shift: floor-shift accumulator right by FRAC_BITS and saturate to N_BITS
// ports: a_i accumulator in, y_o saturated sample, ovf_o high when clipped
module iir_sat_shift #(
  parameter int N_BITS = 32,
  parameter int FRAC_BITS = 16,
  parameter int AW = 67
) (
  input  logic signed [AW-1:0]     a_i,
  output logic signed [N_BITS-1:0] y_o,
  output logic                     ovf_o
);
  logic signed [AW-1:0] sh;
  logic [AW-N_BITS:0] top;
  assign sh = a_i >>> FRAC_BITS;
  assign top = sh[AW-1:N_BITS-1];
  assign ovf_o = !((&top) || !(|top));
  assign y_o = ovf_o ? {sh[AW-1], {(N_BITS-1){~sh[AW-1]}}} : sh[N_BITS-1:0];
endmodule

// File: rtl/iir_biquad_cascade.sv
// iir_biquad_cascade: N_SECTIONS DF-II biquads on one time-multiplexed MAC
// ports: clk/reset (async, active-low); x_i/x_valid_i/x_ready_o sample in;
// coef_we_i/coef_addr_i/coef_data_i coefficient bank write (IDLE only);
// clear_i state clear/abort; y_o/y_valid_o/ovf_o result out
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter int N_BITS = 32,
  parameter int FRAC_BITS = 16,
  parameter int N_SECTIONS = 2
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [N_BITS-1:0]                              x_i,
  input  logic                                           x_valid_i,
  output logic                                           x_ready_o,
  input  logic                                           coef_we_i,
  input  logic [$clog2(COEFS_PER_SEC*N_SECTIONS)-1:0]    coef_addr_i,
  input  logic [N_BITS-1:0]                              coef_data_i,
  input  logic                                           clear_i,
  output logic [N_BITS-1:0]                              y_o,
  output logic                                           y_valid_o,
  output logic                                           ovf_o
);
  localparam int AW = acc_width(N_BITS);
  localparam int NC = COEFS_PER_SEC * N_SECTIONS;
  localparam int AB = $clog2(NC);
  localparam int SW = N_SECTIONS > 1 ? $clog2(N_SECTIONS) : 1;
  state_t state_q;
  logic signed [AW-1:0] acc_q, acc_d, sat_in, x_ext, ys_ext, prod_ext;
  logic [SW-1:0] sec_q;
  logic signed [N_BITS-1:0] w0_q, c, w, ys;
  logic signed [N_BITS-1:0] w1_q [N_SECTIONS];
  logic signed [N_BITS-1:0] w2_q [N_SECTIONS];
  logic signed [N_BITS-1:0] coef_q [NC];
  logic signed [2*N_BITS-1:0] prod;
  logic [2:0] k;
  logic [AB-1:0] cidx;
  logic sticky_q, sovf;
  assign x_ready_o = state_q == IDLE;
  always_comb begin
    k = state_q == MAC0 ? A1 : state_q == MAC1 ? A2 : state_q == MAC2 ? B0 : state_q == MAC3 ? B1 : B2;
    cidx = AB'(int'(sec_q) * COEFS_PER_SEC + int'(k));
    c = coef_q[cidx];
    w = state_q == MAC2 ? w0_q : (state_q == MAC0 || state_q == MAC3) ? w1_q[sec_q] : w2_q[sec_q];
    prod = c * w;
    prod_ext = prod;
    acc_d = (state_q == MAC0 || state_q == MAC1) ? acc_q - prod_ext : acc_q + prod_ext;
    sat_in = state_q == UPD ? acc_q : acc_d;
    x_ext = $signed(x_i);
    ys_ext = ys;
  end
  iir_sat_shift #(.N_BITS(N_BITS), .FRAC_BITS(FRAC_BITS), .AW(AW)) u_sat (
    .a_i(sat_in), .y_o(ys), .ovf_o(sovf)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      sec_q <= '0;
      w0_q <= '0;
      sticky_q <= 1'b0;
      y_o <= '0;
      y_valid_o <= 1'b0;
      ovf_o <= 1'b0;
      for (int i = 0; i < N_SECTIONS; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
      end
      for (int i = 0; i < NC; i++) coef_q[i] <= '0;
    end else begin
      y_valid_o <= 1'b0;
      if (state_q == IDLE && coef_we_i && int'(coef_addr_i) < NC) coef_q[coef_addr_i] <= coef_data_i;
      if (clear_i) begin
        state_q <= IDLE;
        for (int i = 0; i < N_SECTIONS; i++) begin
          w1_q[i] <= '0;
          w2_q[i] <= '0;
        end
      end else
        case (state_q)
          IDLE: if (x_valid_i) begin
            acc_q <= x_ext <<< FRAC_BITS;
            sec_q <= '0;
            sticky_q <= 1'b0;
            state_q <= MAC0;
          end
          MAC0: begin
            acc_q <= acc_d;
            state_q <= MAC1;
          end
          MAC1: begin
            w0_q <= ys;
            sticky_q <= sticky_q | sovf;
            acc_q <= '0;
            state_q <= MAC2;
          end
          MAC2: begin
            acc_q <= acc_d;
            state_q <= MAC3;
          end
          MAC3: begin
            acc_q <= acc_d;
            state_q <= MAC4;
          end
          MAC4: begin
            acc_q <= acc_d;
            state_q <= UPD;
          end
          UPD: begin
            w2_q[sec_q] <= w1_q[sec_q];
            w1_q[sec_q] <= w0_q;
            sticky_q <= sticky_q | sovf;
            if (sec_q == SW'(N_SECTIONS - 1)) begin
              y_o <= ys;
              y_valid_o <= 1'b1;
              ovf_o <= sticky_q | sovf;
              state_q <= IDLE;
            end else begin
              acc_q <= ys_ext <<< FRAC_BITS;
              sec_q <= sec_q + 1'b1;
              state_q <= MAC0;
            end
          end
          default: state_q <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// tb_iir_biquad_cascade: directed self-checking bench for the biquad cascade
module tb_iir_biquad_cascade;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [31:0] x_i = '0;
  logic x_valid_i = 1'b0;
  logic coef_we_i = 1'b0;
  logic [3:0] coef_addr_i = '0;
  logic [31:0] coef_data_i = '0;
  logic clear_i = 1'b0;
  logic [31:0] y_o;
  logic x_ready_o, y_valid_o, ovf_o;
  int checks = 0;
  int errors = 0;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] HALF_NEG = 32'hFFFF_8000;
  always #5 clk = ~clk;
  iir_biquad_cascade dut (
    .clk(clk), .reset(reset), .x_i(x_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_data_i(coef_data_i),
    .clear_i(clear_i), .y_o(y_o), .y_valid_o(y_valid_o), .ovf_o(ovf_o)
  );
  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    coef_we_i = 1'b1;
    coef_addr_i = 4'(a);
    coef_data_i = d;
    @(negedge clk);
    coef_we_i = 1'b0;
  endtask
  task automatic set_sec(input int s, input logic [31:0] b0, b1, b2, a1, a2);
    wr(5 * s, b0);
    wr(5 * s + 1, b1);
    wr(5 * s + 2, b2);
    wr(5 * s + 3, a1);
    wr(5 * s + 4, a2);
  endtask
  task automatic clr();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask
  task automatic wait_y(output int lat, output int rdy_low);
    lat = 0;
    rdy_low = 0;
    while (!y_valid_o && lat < 40) begin
      if (!x_ready_o) rdy_low++;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic run_sample(input logic [31:0] x, output logic [31:0] y, output logic o, output int lat, output int rdy_low);
    x_i = x;
    x_valid_i = 1'b1;
    @(negedge clk);
    x_valid_i = 1'b0;
    wait_y(lat, rdy_low);
    y = y_o;
    o = ovf_o;
  endtask
  task automatic test_reset();
    logic [31:0] y;
    logic o;
    int lat, rl;
    checks += 4;
    if (y_o !== 32'h0) begin errors++; $display("FAIL reset_y: got %h expected 00000000", y_o); end
    if (y_valid_o !== 1'b0) begin errors++; $display("FAIL reset_yv: got %b expected 0", y_valid_o); end
    if (x_ready_o !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", x_ready_o); end
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_o); end
    set_sec(0, ONE, 0, 0, 0, 0);
    set_sec(1, ONE, 0, 0, 0, 0);
    run_sample(32'h0003_0000, y, o, lat, rl);
    checks++;
    if (y !== 32'h0003_0000) begin errors++; $display("FAIL pre_reset_y: got %h expected 00030000", y); end
    x_i = ONE;
    x_valid_i = 1'b1;
    @(negedge clk);
    x_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 4;
    if (y_o !== 32'h0) begin errors++; $display("FAIL midrst_y: got %h expected 00000000", y_o); end
    if (y_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_yv: got %b expected 0", y_valid_o); end
    if (x_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_rdy: got %b expected 1", x_ready_o); end
    if (ovf_o !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b expected 0", ovf_o); end
    @(negedge clk);
    reset = 1'b1;
    run_sample(ONE, y, o, lat, rl);
    checks += 2;
    if (y !== 32'h0) begin errors++; $display("FAIL zero_coef_y: got %h expected 00000000", y); end
    if (lat !== 12) begin errors++; $display("FAIL zero_coef_lat: got %0d expected 12", lat); end
  endtask
  task automatic test_passthrough();
    logic [31:0] y;
    logic o;
    int lat, rl;
    clr();
    set_sec(0, ONE, 0, 0, 0, 0);
    set_sec(1, ONE, 0, 0, 0, 0);
    run_sample(32'h0003_0000, y, o, lat, rl);
    checks += 4;
    if (y !== 32'h0003_0000) begin errors++; $display("FAIL pass_y: got %h expected 00030000", y); end
    if (lat !== 12) begin errors++; $display("FAIL pass_lat: got %0d expected 12", lat); end
    if (rl !== 12) begin errors++; $display("FAIL pass_rdy_low: got %0d expected 12", rl); end
    if (o !== 1'b0) begin errors++; $display("FAIL pass_ovf: got %b expected 0", o); end
    @(negedge clk);
    checks += 2;
    if (y_valid_o !== 1'b0) begin errors++; $display("FAIL pass_pulse: got %b expected 0", y_valid_o); end
    if (y_o !== 32'h0003_0000) begin errors++; $display("FAIL pass_hold: got %h expected 00030000", y_o); end
    run_sample(32'hFFFD_0000, y, o, lat, rl);
    run_sample(32'h0000_8000, y, o, lat, rl);
    checks += 2;
    if (y !== 32'h0000_8000) begin errors++; $display("FAIL b2b_y: got %h expected 00008000", y); end
    if (lat !== 12) begin errors++; $display("FAIL b2b_lat: got %0d expected 12", lat); end
  endtask
  task automatic test_feedback();
    logic [31:0] y;
    logic o;
    int lat, rl;
    logic [31:0] e [4];
    e = '{32'h0001_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_2000};
    clr();
    set_sec(0, ONE, 0, 0, HALF_NEG, 0);
    set_sec(1, ONE, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_sample(i == 0 ? ONE : 32'h0, y, o, lat, rl);
      checks++;
      if (y !== e[i]) begin errors++; $display("FAIL impulse_%0d: got %h expected %h", i, y, e[i]); end
    end
  endtask
  task automatic test_saturation();
    logic [31:0] y;
    logic o;
    int lat, rl;
    clr();
    set_sec(0, 32'h0002_0000, 0, 0, 0, 0);
    set_sec(1, ONE, 0, 0, 0, 0);
    run_sample(32'h7FFF_0000, y, o, lat, rl);
    checks += 2;
    if (y !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_pos_y: got %h expected 7fffffff", y); end
    if (o !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf: got %b expected 1", o); end
    run_sample(32'h8000_0000, y, o, lat, rl);
    checks += 2;
    if (y !== 32'h8000_0000) begin errors++; $display("FAIL sat_neg_y: got %h expected 80000000", y); end
    if (o !== 1'b1) begin errors++; $display("FAIL sat_neg_ovf: got %b expected 1", o); end
    run_sample(ONE, y, o, lat, rl);
    checks += 2;
    if (y !== 32'h0002_0000) begin errors++; $display("FAIL sat_after_y: got %h expected 00020000", y); end
    if (o !== 1'b0) begin errors++; $display("FAIL sat_after_ovf: got %b expected 0", o); end
  endtask
  task automatic test_clear_abort();
    logic [31:0] y;
    logic o;
    int lat, rl, seen;
    logic [31:0] e [3];
    e = '{32'h0001_0000, 32'h0000_8000, 32'h0000_4000};
    clr();
    set_sec(0, ONE, 0, 0, HALF_NEG, 0);
    set_sec(1, ONE, 0, 0, 0, 0);
    run_sample(ONE, y, o, lat, rl);
    run_sample(32'h0, y, o, lat, rl);
    checks++;
    if (y !== 32'h0000_8000) begin errors++; $display("FAIL clr_pre_y: got %h expected 00008000", y); end
    x_i = 32'h0;
    x_valid_i = 1'b1;
    @(negedge clk);
    x_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    checks++;
    if (x_ready_o !== 1'b1) begin errors++; $display("FAIL clr_rdy: got %b expected 1", x_ready_o); end
    seen = 0;
    repeat (15) begin
      if (y_valid_o) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL clr_no_valid: got %0d pulses expected 0", seen); end
    for (int i = 0; i < 3; i++) begin
      run_sample(i == 0 ? ONE : 32'h0, y, o, lat, rl);
      checks++;
      if (y !== e[i]) begin errors++; $display("FAIL clr_impulse_%0d: got %h expected %h", i, y, e[i]); end
    end
  endtask
  task automatic test_coef_guard();
    logic [31:0] y;
    logic o;
    int lat, rl;
    clr();
    set_sec(0, ONE, 0, 0, 0, 0);
    set_sec(1, ONE, 0, 0, 0, 0);
    x_i = 32'h0003_0000;
    x_valid_i = 1'b1;
    @(negedge clk);
    x_valid_i = 1'b0;
    coef_we_i = 1'b1;
    coef_addr_i = 4'd0;
    coef_data_i = 32'h0;
    @(negedge clk);
    coef_we_i = 1'b0;
    wait_y(lat, rl);
    checks += 2;
    if (y_o !== 32'h0003_0000) begin errors++; $display("FAIL busy_we_y: got %h expected 00030000", y_o); end
    if (lat !== 11) begin errors++; $display("FAIL busy_we_lat: got %0d expected 11", lat); end
    wr(10, 32'h0);
    run_sample(32'h0003_0000, y, o, lat, rl);
    checks += 2;
    if (y !== 32'h0003_0000) begin errors++; $display("FAIL oob_we_y: got %h expected 00030000", y); end
    if (lat !== 12) begin errors++; $display("FAIL oob_we_lat: got %0d expected 12", lat); end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_feedback();
    test_saturation();
    test_clear_abort();
    test_coef_guard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
